// File: rtl/seq_signed_divider_pkg.sv
// Shared types and defaults for the sequential signed divider.
package seq_signed_divider_pkg;

  localparam int DEFAULT_BITWIDTH = 16;
  localparam int DEFAULT_CNT_W    = $clog2(DEFAULT_BITWIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_signed_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, compare, conditionally subtract.
module seq_signed_divider_div_step
  import seq_signed_divider_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] rem_in,
  input  logic                bit_in,
  input  logic [BITWIDTH-1:0] divisor_mag,
  output logic [BITWIDTH-1:0] rem_out,
  output logic                q_bit
);

  logic [BITWIDTH:0] shifted;

  // The true result always fits BITWIDTH bits, so the low-bit subtract is exact.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor_mag});
    rem_out = q_bit ? (shifted[BITWIDTH-1:0] - divisor_mag) : shifted[BITWIDTH-1:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: magnitude restoring division, one quotient bit per clock, sign fix at the end.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  localparam int CNT_W = $clog2(BITWIDTH);
  localparam logic [BITWIDTH-1:0] MIN_VAL = {1'b1, {(BITWIDTH-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BITWIDTH-1:0] dvd_q, dvd_d;
  logic [BITWIDTH-1:0] dvs_q, dvs_d;
  logic [BITWIDTH-1:0] rem_q, rem_d;
  logic                sd_q, sd_d;
  logic                sv_q, sv_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BITWIDTH-1:0] quotient_q, quotient_d;
  logic [BITWIDTH-1:0] remainder_q, remainder_d;
  logic                div_by_zero_q, div_by_zero_d;
  logic                overflow_q, overflow_d;

  logic [BITWIDTH-1:0] step_rem;
  logic                step_q_bit;

  seq_signed_divider_div_step #(
    .BITWIDTH(BITWIDTH)
  ) u_div_step (
    .rem_in     (rem_q),
    .bit_in     (dvd_q[BITWIDTH-1]),
    .divisor_mag(dvs_q),
    .rem_out    (step_rem),
    .q_bit      (step_q_bit)
  );

  // dvd_q doubles as the quotient accumulator: dividend bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    sd_d          = sd_q;
    sv_d          = sv_q;
    dbz_d         = dbz_q;
    ovf_d         = ovf_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend[BITWIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[BITWIDTH-1] ? -divisor : divisor;
          rem_d   = '0;
          sd_d    = dividend[BITWIDTH-1];
          sv_d    = divisor[BITWIDTH-1];
          dbz_d   = (divisor == '0);
          ovf_d   = (dividend == MIN_VAL) && (divisor == '1);
          cnt_d   = CNT_W'(BITWIDTH - 1);
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[BITWIDTH-2:0], step_q_bit};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        // With a zero divisor every step subtracts nothing, leaving |dividend| as the remainder.
        if (dbz_q) begin
          quotient_d = '1;
        end else begin
          quotient_d = (sd_q ^ sv_q) ? -dvd_q : dvd_q;
        end
        remainder_d   = sd_q ? -rem_q : rem_q;
        div_by_zero_d = dbz_q;
        overflow_d    = ovf_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      sd_q          <= 1'b0;
      sv_q          <= 1'b0;
      dbz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      sd_q          <= sd_d;
      sv_q          <= sv_d;
      dbz_q         <= dbz_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: expected results queued at issue, checked on done.
module tb_seq_signed_divider;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  seq_signed_divider #(.BITWIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model built on the simulator's native 32-bit signed division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
      e.ovf = 1'b0;
    end else begin
      e.q = W'(ai / bi);
      e.r = W'(ai % bi);
      e.dbz = 1'b0;
      e.ovf = (a == 16'h8000) && (b == 16'hFFFF);
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      $display("[TB] FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, need all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, need 0 0", busy, done);
      miscompares++;
    end
  endtask

  task automatic test_basic_latency();
    exp_t e;
    issue(16'd100, 16'd7);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        $display("[TB] FAIL busy_window edge %0d: got busy=%b done=%b, need 1 0", k, busy, done);
        miscompares++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 ||
        {quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
      $display("[TB] FAIL basic_100_7: got done=%b busy=%b q=%h r=%h dbz=%b ovf=%b, need 1 0 %h %h %b %b",
               done, busy, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
      miscompares++;
    end
    last_q = e.q;
    last_r = e.r;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      $display("[TB] FAIL done_pulse_width: got done=%b, need 0", done);
      miscompares++;
    end
  endtask

  task automatic test_signs_and_edges();
    logic [W-1:0] ta[17];
    logic [W-1:0] tb[17];
    exp_t e;
    int   n;
    ta = '{16'(-100), 16'd100, 16'(-100), 16'd1234, 16'h8000, 16'h8000, 16'(-1234), 16'd7,
           16'(-7), 16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tb = '{16'd7, 16'(-7), 16'(-7), 16'd0, 16'hFFFF, 16'd1, 16'd0, 16'd100,
           16'd100, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 11; i < 17; i++) begin
      ta[i] = W'($urandom);
      tb[i] = W'($urandom_range(1, 300));
      if (i % 2 == 0) tb[i] = -tb[i];
    end
    for (int i = 0; i < 17; i++) begin
      issue(ta[i], tb[i]);
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          vectors++;
          if (quotient !== last_q || remainder !== last_r) begin
            $display("[TB] FAIL result_hold[%0d]: got q=%h r=%h, need %h %h",
                     i, quotient, remainder, last_q, last_r);
            miscompares++;
          end
        end
        if (done === 1'b1) break;
      end
      e = sb.pop_front();
      vectors++;
      if (done !== 1'b1) begin
        $display("[TB] FAIL timeout[%0d]: got no done in %0d cycles, need done at 18", i, n);
        miscompares++;
      end else if (n != 18 ||
                   {quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
        $display("[TB] FAIL op[%0d] %h/%h: got lat=%0d q=%h r=%h dbz=%b ovf=%b, need 18 %h %h %b %b",
                 i, ta[i], tb[i], n, quotient, remainder, div_by_zero, overflow,
                 e.q, e.r, e.dbz, e.ovf);
        miscompares++;
      end
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    dividend = W'($urandom);
    divisor = W'($urandom_range(1, 1000));
    sb.push_back(model(dividend, divisor));
    for (int cyc = 0; cyc < 54; cyc++) begin
      @(posedge clk); #1;
      dividend = W'($urandom);
      divisor = W'($urandom_range(0, 2000));
      if (cyc == 53) start = 1'b0;
      else if ((cyc + 1) % 18 == 0) sb.push_back(model(dividend, divisor));
      @(negedge clk);
      vectors++;
      if (cyc % 18 == 17) begin
        e = sb.pop_front();
        if (done !== 1'b1 ||
            {quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
          $display("[TB] FAIL b2b cycle %0d: got done=%b q=%h r=%h dbz=%b ovf=%b, need 1 %h %h %b %b",
                   cyc, done, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
          miscompares++;
        end
        last_q = e.q;
        last_r = e.r;
      end else if (done !== 1'b0) begin
        $display("[TB] FAIL b2b_spurious_done cycle %0d: got done=%b, need 0", cyc, done);
        miscompares++;
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL b2b_queue: got %0d pending, need 0", sb.size());
      miscompares++;
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   n;
    logic saw_done;
    @(posedge clk); #1;
    start = 1'b1;
    dividend = 16'd100;
    divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      $display("[TB] FAIL async_reset: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, need all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
      miscompares++;
    end
    last_q = '0;
    last_r = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      $display("[TB] FAIL aborted_op_activity: got done/busy after abort, need none");
      miscompares++;
    end
    issue(16'd9, 16'd3);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || n != 18 ||
        {quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
      $display("[TB] FAIL post_reset_9_3: got done=%b lat=%0d q=%h r=%h, need 1 18 %h %h",
               done, n, quotient, remainder, e.q, e.r);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_signs_and_edges();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
